// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmitter among four byte producers.
// Defining UART_ARB_TIMEOUT_EN adds a WAIT-state watchdog that abandons a byte and flags TIMEOUT_ERR.
module uart_tx_arbiter #(
  parameter int unsigned TRG_LEN        = 4,
  parameter int unsigned GAP_LEN        = 0,
  parameter int unsigned TIMEOUT_CYCLES = 10000
) (
  input  logic        CLK_50MHZ,
  input  logic        RST,
  input  logic [3:0]  REQ,
  input  logic [31:0] DATA_BUS,
  output logic [3:0]  GNT,
  output logic [3:0]  SENT,
  output logic        BUSY,
  output logic [7:0]  UART_DATA,
  output logic        UART_TRG_WRITE,
  input  logic        UART_DONE,
  output logic        TIMEOUT_ERR
);

  typedef enum logic [1:0] {StIdle, StTrig, StWait, StGap} state_e;

  state_e      state_q;
  logic [1:0]  ptr_q;
  logic [1:0]  cur_q;
  logic [1:0]  win_idx;
  logic [1:0]  cand;
  logic        win_found;
  logic [15:0] cnt_q;
  logic        done_q;
  logic        done_rise;
  logic        finish;

  assign done_rise = UART_DONE & ~done_q;

  // First pending requester searching upward from ptr_q, wrapping mod 4.
  always_comb begin
    win_found = 1'b0;
    win_idx   = ptr_q;
    cand      = ptr_q;
    for (int k = 0; k < 4; k++) begin
      cand = ptr_q + 2'(k);
      if (!win_found && REQ[cand]) begin
        win_found = 1'b1;
        win_idx   = cand;
      end
    end
  end

`ifdef UART_ARB_TIMEOUT_EN
  logic [15:0] wd_q;
  logic        wd_hit;

  // A real DONE edge on the last watchdog cycle still wins over the timeout.
  assign wd_hit = (state_q == StWait) && !done_rise && (wd_q == 16'(TIMEOUT_CYCLES - 1));
  assign finish = done_rise | wd_hit;

  always_ff @(posedge CLK_50MHZ or posedge RST) begin
    if (RST) begin
      wd_q        <= '0;
      TIMEOUT_ERR <= 1'b0;
    end else begin
      if (state_q != StWait) wd_q <= '0;
      else                   wd_q <= wd_q + 16'd1;
      if (wd_hit) TIMEOUT_ERR <= 1'b1;
    end
  end
`else
  assign finish      = done_rise;
  assign TIMEOUT_ERR = 1'b0;
`endif

  always_ff @(posedge CLK_50MHZ or posedge RST) begin
    if (RST) begin
      state_q        <= StIdle;
      ptr_q          <= '0;
      cur_q          <= '0;
      cnt_q          <= '0;
      done_q         <= 1'b0;
      GNT            <= '0;
      SENT           <= '0;
      BUSY           <= 1'b0;
      UART_DATA      <= '0;
      UART_TRG_WRITE <= 1'b0;
    end else begin
      done_q <= UART_DONE;
      GNT    <= '0;
      SENT   <= '0;
      unique case (state_q)
        StIdle: begin
          if (win_found) begin
            cur_q          <= win_idx;
            UART_DATA      <= DATA_BUS[8*win_idx +: 8];
            GNT            <= 4'b0001 << win_idx;
            UART_TRG_WRITE <= 1'b1;
            BUSY           <= 1'b1;
            cnt_q          <= 16'(TRG_LEN - 1);
            state_q        <= StTrig;
          end
        end
        StTrig: begin
          if (cnt_q == 16'd0) begin
            UART_TRG_WRITE <= 1'b0;
            state_q        <= StWait;
          end else begin
            cnt_q <= cnt_q - 16'd1;
          end
        end
        StWait: begin
          if (finish) begin
            if (done_rise) SENT <= 4'b0001 << cur_q;
            ptr_q <= cur_q + 2'd1;
            if (GAP_LEN == 0) begin
              state_q <= StIdle;
              BUSY    <= 1'b0;
            end else begin
              cnt_q   <= 16'(GAP_LEN - 1);
              state_q <= StGap;
            end
          end
        end
        StGap: begin
          if (cnt_q == 16'd0) begin
            state_q <= StIdle;
            BUSY    <= 1'b0;
          end else begin
            cnt_q <= cnt_q - 16'd1;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Scoreboard bench for uart_tx_arbiter: stimulus queues expected grants/completions, a monitor
// pops and compares them whenever GNT or SENT pulses.
module tb_uart_tx_arbiter;

  logic        CLK_50MHZ = 1'b0;
  logic        RST;
  logic [3:0]  REQ;
  logic [31:0] DATA_BUS;
  logic [3:0]  GNT;
  logic [3:0]  SENT;
  logic        BUSY;
  logic [7:0]  UART_DATA;
  logic        UART_TRG_WRITE;
  logic        UART_DONE;
  logic        TIMEOUT_ERR;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [1:0] idx;
    logic [7:0] data;
  } gnt_t;

  gnt_t       exp_gnt[$];
  logic [1:0] exp_sent[$];
  gnt_t       e_g;
  logic [1:0] e_s;
  int         trg_run = 0;

  always #10 CLK_50MHZ = ~CLK_50MHZ;

  uart_tx_arbiter #(
    .TRG_LEN       (4),
    .GAP_LEN       (0),
    .TIMEOUT_CYCLES(100)
  ) dut (
    .CLK_50MHZ     (CLK_50MHZ),
    .RST           (RST),
    .REQ           (REQ),
    .DATA_BUS      (DATA_BUS),
    .GNT           (GNT),
    .SENT          (SENT),
    .BUSY          (BUSY),
    .UART_DATA     (UART_DATA),
    .UART_TRG_WRITE(UART_TRG_WRITE),
    .UART_DONE     (UART_DONE),
    .TIMEOUT_ERR   (TIMEOUT_ERR)
  );

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK_50MHZ);
    #1;
  endtask

  task automatic wait_gnt(input string nm);
    int n = 0;
    while (GNT == 4'b0000 && n < 40) begin
      tick();
      n++;
    end
    check({nm, "_gnt_seen"}, 32'(GNT != 4'b0000), 1);
  endtask

  task automatic wait_trg_fall(input string nm);
    int n = 0;
    while (UART_TRG_WRITE && n < 40) begin
      tick();
      n++;
    end
    check({nm, "_trg_low"}, 32'(UART_TRG_WRITE), 0);
  endtask

  task automatic pulse_done(input logic [1:0] idx);
    exp_sent.push_back(idx);
    UART_DONE = 1'b1;
    tick();
    UART_DONE = 1'b0;
  endtask

  // Monitor: compare every grant/completion pulse and every TRG_WRITE run length.
  always @(negedge CLK_50MHZ) begin
    if (!RST) begin
      if (GNT != 4'b0000) begin
        if (exp_gnt.size() == 0) check("gnt_unexpected", 32'(GNT), 0);
        else begin
          e_g = exp_gnt.pop_front();
          check("gnt_onehot", 32'(GNT), 32'(4'b0001 << e_g.idx));
          check("gnt_data", 32'(UART_DATA), 32'(e_g.data));
        end
      end
      if (SENT != 4'b0000) begin
        if (exp_sent.size() == 0) check("sent_unexpected", 32'(SENT), 0);
        else begin
          e_s = exp_sent.pop_front();
          check("sent_onehot", 32'(SENT), 32'(4'b0001 << e_s));
        end
      end
      if (UART_TRG_WRITE) trg_run++;
      else if (trg_run != 0) begin
        check("trg_len", trg_run, 4);
        trg_run = 0;
      end
    end else begin
      trg_run = 0;
    end
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "time limit");
  end

  initial begin
    RST = 1'b1; REQ = '0; DATA_BUS = '0; UART_DONE = 1'b0;
    tick();
    check("rst_gnt", 32'(GNT), 0);
    check("rst_sent", 32'(SENT), 0);
    check("rst_busy", 32'(BUSY), 0);
    check("rst_data", 32'(UART_DATA), 0);
    check("rst_trg", 32'(UART_TRG_WRITE), 0);
    check("rst_err", 32'(TIMEOUT_ERR), 0);
    tick();
    RST = 1'b0;
    tick();

    // Round robin from ptr 0 with all four requesting.
    DATA_BUS = 32'h13121110;
    exp_gnt.push_back('{2'd0, 8'h10});
    exp_gnt.push_back('{2'd1, 8'h11});
    exp_gnt.push_back('{2'd2, 8'h12});
    exp_gnt.push_back('{2'd3, 8'h13});
    exp_gnt.push_back('{2'd0, 8'h10});
    REQ = 4'b1111;
    for (int i = 0; i < 5; i++) begin
      wait_gnt("rr");
      if (i == 4) REQ = 4'b0000;
      wait_trg_fall("rr");
      repeat (3) tick();
      pulse_done(2'(i % 4));
    end
    check("rr_busy_idle", 32'(BUSY), 0);

    // Single request on lane 2, DONE 50 cycles after TRG drops.
    DATA_BUS = 32'h00A50000;
    exp_gnt.push_back('{2'd2, 8'hA5});
    REQ = 4'b0100;
    wait_gnt("single");
    check("single_data", 32'(UART_DATA), 32'h000000A5);
    check("single_trg", 32'(UART_TRG_WRITE), 1);
    check("single_busy", 32'(BUSY), 1);
    REQ = 4'b0000;
    wait_trg_fall("single");
    repeat (50) tick();
    check("single_wait_busy", 32'(BUSY), 1);
    pulse_done(2'd2);
    check("single_busy_idle", 32'(BUSY), 0);
    tick();
    check("single_data_hold", 32'(UART_DATA), 32'h000000A5);

    // Fairness: ptr now 3, so 0 wins over 2.
    DATA_BUS = 32'hD3C2B1A0;
    exp_gnt.push_back('{2'd0, 8'hA0});
    exp_gnt.push_back('{2'd2, 8'hC2});
    REQ = 4'b0101;
    wait_gnt("fair0");
    REQ = 4'b0100;
    wait_trg_fall("fair0");
    tick();
    pulse_done(2'd0);
    wait_gnt("fair2");
    REQ = 4'b0000;
    wait_trg_fall("fair2");
    pulse_done(2'd2);

    // Stale DONE held high from before the grant.
    UART_DONE = 1'b1;
    tick();
    exp_gnt.push_back('{2'd1, 8'hB1});
    REQ = 4'b0010;
    wait_gnt("stale");
    REQ = 4'b0000;
    wait_trg_fall("stale");
    repeat (5) tick();
    check("stale_busy", 32'(BUSY), 1);
    check("stale_no_sent", 32'(SENT), 0);
    UART_DONE = 1'b0;
    tick();
    exp_sent.push_back(2'd1);
    UART_DONE = 1'b1;
    tick();
    check("stale_busy_idle", 32'(BUSY), 0);
    repeat (3) tick();
    UART_DONE = 1'b0;
    tick();

    // Asynchronous reset while waiting for DONE.
    exp_gnt.push_back('{2'd3, 8'hD3});
    REQ = 4'b1000;
    wait_gnt("rstmid");
    REQ = 4'b0000;
    wait_trg_fall("rstmid");
    tick();
    tick();
    check("rstmid_busy_before", 32'(BUSY), 1);
    #3;
    RST = 1'b1;
    #1;
    check("rstmid_gnt", 32'(GNT), 0);
    check("rstmid_sent", 32'(SENT), 0);
    check("rstmid_busy", 32'(BUSY), 0);
    check("rstmid_data", 32'(UART_DATA), 0);
    check("rstmid_trg", 32'(UART_TRG_WRITE), 0);
    check("rstmid_err", 32'(TIMEOUT_ERR), 0);
    REQ = 4'b1010;
    tick();
    tick();
    exp_gnt.push_back('{2'd1, 8'hB1});
    RST = 1'b0;
    wait_gnt("rstpost");
    REQ = 4'b0000;
    wait_trg_fall("rstpost");
    pulse_done(2'd1);

    // Watchdog: DONE never arrives for requester 0 (ptr 2, so 0 is found after 2,3).
    exp_gnt.push_back('{2'd0, 8'hA0});
    REQ = 4'b0001;
    wait_gnt("tmo");
    REQ = 4'b0100;
    wait_trg_fall("tmo");
`ifdef UART_ARB_TIMEOUT_EN
    begin
      int n = 0;
      exp_gnt.push_back('{2'd2, 8'hC2});
      while (!TIMEOUT_ERR && n < 300) begin
        tick();
        n++;
      end
      check("tmo_cycles", n, 100);
      wait_gnt("tmo_next");
      REQ = 4'b0000;
      wait_trg_fall("tmo_next");
      pulse_done(2'd2);
      check("tmo_sticky", 32'(TIMEOUT_ERR), 1);
      check("tmo_busy_idle", 32'(BUSY), 0);
    end
`else
    repeat (150) tick();
    check("notmo_busy", 32'(BUSY), 1);
    check("notmo_err", 32'(TIMEOUT_ERR), 0);
`endif

    tick();
    tick();
    check("sb_gnt_drained", exp_gnt.size(), 0);
    check("sb_sent_drained", exp_sent.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/uart_tx_arbiter.md
# uart_tx_arbiter

Shares the single UART transmitter among four on-chip byte producers, e.g. scoreboard display, debug echo, status reporter and host reply. Picks one pending requester round-robin and presents its byte on the UART `DATA_IN`. Pulses `TRG_WRITE`, then waits for the UART's `DONE` before serving the next requester. Sits between the producers and the `UART` instance, clocked from `CLK_50MHZ`.

## Interface
- `TRG_LEN`, default 4: cycles `UART_TRG_WRITE` is held high per byte (1..65535).
- `GAP_LEN`, default 0: idle cycles inserted after each byte before the next grant (0..65535).
- `TIMEOUT_CYCLES`, default 10000: WAIT-state watchdog limit (1..65535). Used only with `UART_ARB_TIMEOUT_EN`.

Ports:
- `CLK_50MHZ`  in  1  system clock, rising edge.
- `RST`  in  1  reset, asynchronous, active-high.
- `REQ`  in  4  per-requester request level; bit i = requester i.
- `DATA_BUS`  in  32  requester i byte at `[8i+7:8i]`.
- `GNT`  out  4  one-hot, one-cycle pulse: byte of requester i captured.
- `SENT`  out  4  one-hot, one-cycle pulse: byte of requester i completed (`DONE` seen).
- `BUSY`  out  1  high whenever state ≠ IDLE.
- `UART_DATA`  out  8  to UART `DATA_IN`.
- `UART_TRG_WRITE`  out  1  to UART `TRG_WRITE`.
- `UART_DONE`  in  1  from UART `DONE`; level, rising edge is significant.
- `TIMEOUT_ERR`  out  1  sticky watchdog flag.

## Operation
- States: IDLE, TRIG, WAIT, GAP.
- Round-robin pointer `ptr` (2 bits):
  - Search order is ptr, ptr+1, … mod 4.
  - After a byte completes or is abandoned, ptr = served index + 1 (wraps 3→0).
- IDLE:
  - If REQ ≠ 0, select the winner i.
  - Register `UART_DATA` = byte i, `GNT[i]`=1, `UART_TRG_WRITE`=1.
  - Load the counter with TRG_LEN-1 and go to TRIG.
- TRIG:
  - Decrement the counter; at 0, drop `UART_TRG_WRITE` and go to WAIT.
  - `UART_DONE` edges are ignored.
- WAIT:
  - On a `UART_DONE` rising edge (`DONE & ~done_q`, with `done_q` registered every cycle), pulse `SENT[i]`.
  - Advance ptr.
  - If GAP_LEN=0, go to IDLE; otherwise load the counter with GAP_LEN-1 and go to GAP.
- GAP: count down to 0, then go to IDLE.
- `UART_DATA` holds the last byte until the next grant.
- Requester contract:
  - Hold REQ and the byte stable until GNT.
  - May drop REQ after GNT.
  - A REQ still high in IDLE after SENT is a new byte.
- REQ deasserted before grant: the request is withdrawn, with no side effects.
- The data lane is sampled only in the IDLE grant cycle.
- Counters are 16 bits, unsigned; parameters outside their stated ranges are illegal.

## Timing
- Reset values: `GNT`=0, `SENT`=0, `BUSY`=0, `UART_DATA`=0, `UART_TRG_WRITE`=0, `TIMEOUT_ERR`=0; state IDLE, ptr=0, `done_q`=0.
- Grant latency: REQ sampled high at edge n → `GNT`, `UART_DATA`, `UART_TRG_WRITE` and `BUSY` valid after edge n.
- `UART_TRG_WRITE` is high for exactly TRG_LEN cycles.
- `SENT` is asserted for the one cycle following the edge at which the `DONE` rising edge is registered.
- Back-to-back throughput: a new `GNT` comes no earlier than 1+GAP_LEN cycles after `SENT`.
- `DONE` held high across bytes: only a fresh rising edge in WAIT counts.
- Simultaneous requests are resolved by ptr only; there is no fixed priority.
- `RST` mid-operation: all outputs clear immediately and asynchronously, including `UART_TRG_WRITE`; the in-flight byte is lost with no `SENT`.

## Configuration
- With `UART_ARB_TIMEOUT_EN` defined:
  - A 16-bit watchdog clears on WAIT entry and counts each WAIT cycle.
  - If it reaches TIMEOUT_CYCLES-1 without a `DONE` edge, set `TIMEOUT_ERR`=1 (sticky until `RST`).
  - Emit no `SENT`, advance ptr, and proceed as if completed (GAP or IDLE).
- Without the macro: WAIT lasts indefinitely, `TIMEOUT_ERR` is tied 0 and no watchdog logic exists.

## Test plan
1. Single request:
   - Stimulus: REQ=4'b0100, lane 2=8'hA5.
   - Response: `GNT`=4'b0100 for 1 cycle; `UART_DATA`=8'hA5; `UART_TRG_WRITE` high 4 cycles.
   - Then `DONE` pulses 50 cycles later → `SENT`=4'b0100 for 1 cycle, then `BUSY`=0.
2. Round robin:
   - Stimulus: REQ=4'b1111 held, lanes 8'h10..8'h13, `DONE` returned each time.
   - Response: `UART_DATA` sequence 10,11,12,13,10; `GNT` order 0,1,2,3,0.
3. Pointer fairness:
   - Stimulus: after serving requester 2, REQ=4'b0101.
   - Response: grant to 0 (search from 3), then 2.
4. Stale `DONE`:
   - Stimulus: `DONE` held high from before the grant and through TRIG.
   - Response: no `SENT`; one `DONE` low→high in WAIT gives exactly one `SENT`.
5. Reset mid-WAIT:
   - Stimulus: assert `RST` while `BUSY`=1.
   - Response: all outputs 0 without waiting for a clock edge; the first grant after release goes to the lowest pending index starting at 0.
6. Timeout:
   - With `UART_ARB_TIMEOUT_EN` and TIMEOUT_CYCLES=100, never pulse `DONE`.
   - Response: `TIMEOUT_ERR`=1 after 100 WAIT cycles, no `SENT`, the next pending requester is granted.
   - Without the macro: `BUSY` stays 1 and `TIMEOUT_ERR`=0.
